// File: rtl/audio_word_fetcher.sv
// Flash-to-audio sample feeder: fetches 32-bit words over an Avalon-MM read master,
// keeps a current word plus one prefetched word, and steps the byte index on each tick.
module audio_word_fetcher #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
    parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_tick,
    input  logic              play,
    input  logic              restart,
    output logic              flash_read,
    output logic [ADDR_W-1:0] flash_address,
    input  logic              flash_waitrequest,
    input  logic [31:0]       flash_readdata,
    input  logic              flash_readdatavalid,
    output logic [31:0]       data_out,
    output logic [1:0]        byte_sel,
    output logic              no_audio,
    output logic              underrun
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]        state_reg,      state_next;
    logic [ADDR_W-1:0] addr_reg,       addr_next;
    logic [31:0]       data_reg,       data_next;
    logic [31:0]       pref_reg,       pref_next;
    logic [1:0]        byte_sel_reg,   byte_sel_next;
    logic              cur_valid_reg,  cur_valid_next;
    logic              pref_valid_reg, pref_valid_next;
    logic              no_audio_reg,   no_audio_next;
    logic              underrun_reg,   underrun_next;
    logic              discard_reg,    discard_next;

    logic rd_hit;
    logic step;
    logic accept;

    // Data returned for a read that was in flight across a restart must never be used.
    assign rd_hit = (state_reg == ST_WAIT) && flash_readdatavalid && !discard_reg;
    assign step   = sample_tick && play && cur_valid_reg;
    assign accept = (state_reg == ST_REQ) && !flash_waitrequest;

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        data_next       = data_reg;
        pref_next       = pref_reg;
        byte_sel_next   = byte_sel_reg;
        cur_valid_next  = cur_valid_reg;
        pref_valid_next = pref_valid_reg;
        no_audio_next   = !(play && cur_valid_reg);
        underrun_next   = underrun_reg;
        discard_next    = discard_reg;

        if (restart) begin
            addr_next       = START_ADDR;
            cur_valid_next  = 1'b0;
            pref_valid_next = 1'b0;
            byte_sel_next   = 2'd0;
            no_audio_next   = 1'b1;
            underrun_next   = 1'b0;
            case (state_reg)
                ST_REQ: begin
                    // A read accepted on this very edge is still owed a response.
                    if (accept) begin
                        state_next   = ST_WAIT;
                        discard_next = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (flash_readdatavalid) begin
                        state_next   = ST_IDLE;
                        discard_next = 1'b0;
                    end else begin
                        discard_next = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (play && (!cur_valid_reg || !pref_valid_reg))
                        state_next = ST_REQ;
                end
                ST_REQ: begin
                    if (accept) begin
                        state_next = ST_WAIT;
                        addr_next  = (addr_reg == END_ADDR) ? START_ADDR
                                                            : addr_reg + ADDR_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (flash_readdatavalid) begin
                        state_next   = ST_IDLE;
                        discard_next = 1'b0;
                    end
                end
                default: state_next = ST_IDLE;
            endcase

            if (step) begin
                if (byte_sel_reg != 2'd3) begin
                    byte_sel_next = byte_sel_reg + 2'd1;
                    if (rd_hit) begin
                        pref_next       = flash_readdata;
                        pref_valid_next = 1'b1;
                    end
                end else if (pref_valid_reg) begin
                    data_next     = pref_reg;
                    byte_sel_next = 2'd0;
                    if (rd_hit) begin
                        pref_next       = flash_readdata;
                        pref_valid_next = 1'b1;
                    end else begin
                        pref_valid_next = 1'b0;
                    end
                end else if (rd_hit) begin
                    // Word arrives exactly when it is needed: skip the prefetch slot.
                    data_next     = flash_readdata;
                    byte_sel_next = 2'd0;
                end else begin
                    underrun_next  = 1'b1;
                    no_audio_next  = 1'b1;
                    cur_valid_next = 1'b0;
                end
            end else if (rd_hit) begin
                if (!cur_valid_reg) begin
                    data_next      = flash_readdata;
                    byte_sel_next  = 2'd0;
                    cur_valid_next = 1'b1;
                end else begin
                    pref_next       = flash_readdata;
                    pref_valid_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= START_ADDR;
            data_reg       <= 32'd0;
            pref_reg       <= 32'd0;
            byte_sel_reg   <= 2'd0;
            cur_valid_reg  <= 1'b0;
            pref_valid_reg <= 1'b0;
            no_audio_reg   <= 1'b1;
            underrun_reg   <= 1'b0;
            discard_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            data_reg       <= data_next;
            pref_reg       <= pref_next;
            byte_sel_reg   <= byte_sel_next;
            cur_valid_reg  <= cur_valid_next;
            pref_valid_reg <= pref_valid_next;
            no_audio_reg   <= no_audio_next;
            underrun_reg   <= underrun_next;
            discard_reg    <= discard_next;
        end
    end

    assign flash_read    = (state_reg == ST_REQ);
    assign flash_address = addr_reg;
    assign data_out      = data_reg;
    assign byte_sel      = byte_sel_reg;
    assign no_audio      = no_audio_reg;
    assign underrun      = underrun_reg;

endmodule

// File: tb/tb_audio_word_fetcher.sv
// Directed bench for audio_word_fetcher with a small Avalon flash slave model
// (programmable wait states and read latency) and a log of accepted addresses.
module tb_audio_word_fetcher;

    logic        clk;
    logic        reset_n;
    logic        sample_tick;
    logic        play;
    logic        restart;
    logic        flash_read;
    logic [22:0] flash_address;
    logic        flash_waitrequest   = 1'b0;
    logic [31:0] flash_readdata      = 32'd0;
    logic        flash_readdatavalid = 1'b0;
    logic [31:0] data_out;
    logic [1:0]  byte_sel;
    logic        no_audio;
    logic        underrun;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [4];
    int          ws_target  = 0;
    int          lat_target = 2;
    int          ws_cnt     = 0;
    int          lat_cnt    = 0;
    logic [31:0] acc_data   = 32'd0;
    logic [22:0] acc_log [64];
    int          acc_n      = 0;
    int          n0;
    int          hold_n;

    audio_word_fetcher #(
        .ADDR_W     (23),
        .START_ADDR (23'd0),
        .END_ADDR   (23'd3)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .sample_tick         (sample_tick),
        .play                (play),
        .restart             (restart),
        .flash_read          (flash_read),
        .flash_address       (flash_address),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdata      (flash_readdata),
        .flash_readdatavalid (flash_readdatavalid),
        .data_out            (data_out),
        .byte_sel            (byte_sel),
        .no_audio            (no_audio),
        .underrun            (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flash slave: data is captured at acceptance and returned lat_target cycles later.
    always @(negedge clk) begin
        flash_readdatavalid = 1'b0;
        if (lat_cnt > 0) begin
            lat_cnt = lat_cnt - 1;
            if (lat_cnt == 0) begin
                flash_readdatavalid = 1'b1;
                flash_readdata      = acc_data;
            end
        end
        if (flash_read) begin
            if (ws_cnt < ws_target) begin
                flash_waitrequest = 1'b1;
                ws_cnt            = ws_cnt + 1;
            end else begin
                flash_waitrequest = 1'b0;
                ws_cnt            = 0;
                acc_data          = mem[flash_address[1:0]];
                if (acc_n < 64) acc_log[acc_n] = flash_address;
                acc_n   = acc_n + 1;
                lat_cnt = lat_target;
            end
        end else begin
            flash_waitrequest = 1'b0;
            ws_cnt            = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk) sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        mem[0] = 32'h99775533;
        mem[1] = 32'hDDCCBBAA;
        mem[2] = 32'h11223344;
        mem[3] = 32'h55667788;
        reset_n     = 1'b0;
        sample_tick = 1'b0;
        play        = 1'b0;
        restart     = 1'b0;
        idle(3);

        // Reset state
        chk("rst_read", 32'(flash_read), 32'd0);
        chk("rst_addr", 32'(flash_address), 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_bsel", 32'(byte_sel), 32'd0);
        chk("rst_noaud", 32'(no_audio), 32'd1);
        chk("rst_undr", 32'(underrun), 32'd0);

        // Initial fill and one full word of ticks
        play    = 1'b1;
        reset_n = 1'b1;
        idle(20);
        chk("t1_data0", data_out, 32'h99775533);
        chk("t1_bsel0", 32'(byte_sel), 32'd0);
        chk("t1_noaud", 32'(no_audio), 32'd0);
        chk("t1_accn", 32'(acc_n), 32'd2);
        tick(); chk("t1_bsel1", 32'(byte_sel), 32'd1); idle(10);
        tick(); chk("t1_bsel2", 32'(byte_sel), 32'd2); idle(10);
        tick(); chk("t1_bsel3", 32'(byte_sel), 32'd3); idle(10);
        tick();
        chk("t1_data1", data_out, 32'hDDCCBBAA);
        chk("t1_bsel_wrap", 32'(byte_sel), 32'd0);
        idle(20);
        chk("t1_next_addr", 32'(acc_log[2]), 32'd2);

        // Wait states: request must hold steady until accepted
        ws_target = 10;
        tick(); idle(10);
        tick(); idle(10);
        tick(); idle(10);
        tick();
        chk("t2_data", data_out, 32'h11223344);
        for (int i = 0; i < 40 && !flash_read; i++) @(negedge clk);
        hold_n = 0;
        while (flash_read && hold_n < 40) begin
            if (flash_address == 23'd3) hold_n++;
            @(negedge clk);
        end
        chk("t2_hold_cycles", 32'(hold_n), 32'd11);
        ws_target = 0;
        idle(15);
        chk("t2_single_acc", 32'(acc_n), 32'd4);

        // Address wrap after END_ADDR
        for (int i = 0; i < 4; i++) begin tick(); idle(10); end
        chk("t4_data3", data_out, 32'h55667788);
        idle(5);
        for (int i = 0; i < 4; i++) begin tick(); if (i < 3) idle(10); end
        chk("t4_data0", data_out, 32'h99775533);
        idle(15);
        chk("t4_accn", 32'(acc_n), 32'd6);
        for (int i = 0; i < 6; i++) chk($sformatf("t4_addr%0d", i), 32'(acc_log[i]), 32'(i % 4));

        // Pause at byte_sel=2
        tick(); idle(5);
        tick();
        chk("t5_bsel2", 32'(byte_sel), 32'd2);
        play = 1'b0;
        idle(2);
        chk("t5_noaud_pause", 32'(no_audio), 32'd1);
        for (int i = 0; i < 8; i++) begin tick(); idle(3); end
        chk("t5_bsel_frozen", 32'(byte_sel), 32'd2);
        chk("t5_data_frozen", data_out, 32'h99775533);
        play = 1'b1;
        idle(2);
        chk("t5_noaud_resume", 32'(no_audio), 32'd0);
        tick();
        chk("t5_bsel3", 32'(byte_sel), 32'd3);

        // Underrun: refetch takes longer than four ticks
        lat_target = 80;
        tick();
        chk("t3_data", data_out, 32'hDDCCBBAA);
        for (int i = 0; i < 4; i++) begin idle(10); tick(); end
        chk("t3_underrun", 32'(underrun), 32'd1);
        chk("t3_noaud", 32'(no_audio), 32'd1);
        chk("t3_bsel_held", 32'(byte_sel), 32'd3);
        lat_target = 2;
        idle(3);
        tick();
        chk("t3_bsel_still", 32'(byte_sel), 32'd3);
        for (int i = 0; i < 150 && byte_sel != 2'd0; i++) @(negedge clk);
        idle(2);
        chk("t3_recover_data", data_out, 32'h11223344);
        chk("t3_recover_bsel", 32'(byte_sel), 32'd0);
        chk("t3_recover_noaud", 32'(no_audio), 32'd0);
        chk("t3_sticky", 32'(underrun), 32'd1);

        // Restart while a read is in WAIT: returned word is discarded
        idle(15);
        mem[0]     = 32'h12345678;
        lat_target = 30;
        for (int i = 0; i < 4; i++) begin tick(); if (i < 3) idle(10); end
        chk("t6_data3", data_out, 32'h55667788);
        for (int i = 0; i < 40 && !flash_read; i++) @(negedge clk);
        for (int i = 0; i < 40 && flash_read; i++) @(negedge clk);
        idle(3);
        n0 = acc_n;
        chk("t6_pending_addr", 32'(acc_log[n0 - 1]), 32'd0);
        @(negedge clk) begin
            restart    = 1'b1;
            lat_target = 2;
            mem[0]     = 32'h99775533;
        end
        @(negedge clk) restart = 1'b0;
        chk("t6_rs_undr", 32'(underrun), 32'd0);
        chk("t6_rs_noaud", 32'(no_audio), 32'd1);
        chk("t6_rs_bsel", 32'(byte_sel), 32'd0);
        chk("t6_rs_addr", 32'(flash_address), 32'd0);
        idle(60);
        chk("t6_data", data_out, 32'h99775533);
        chk("t6_noaud", 32'(no_audio), 32'd0);
        chk("t6_accn", 32'(acc_n), 32'(n0 + 2));
        chk("t6_refetch0", 32'(acc_log[n0]), 32'd0);
        chk("t6_refetch1", 32'(acc_log[n0 + 1]), 32'd1);

        // Reset asserted while a request is stalled in REQ
        ws_target = 1000;
        @(negedge clk) restart = 1'b1;
        @(negedge clk) restart = 1'b0;
        for (int i = 0; i < 20 && !flash_read; i++) @(negedge clk);
        chk("t6_req_up", 32'(flash_read), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_read", 32'(flash_read), 32'd0);
        chk("t6_rst_noaud", 32'(no_audio), 32'd1);
        reset_n   = 1'b1;
        ws_target = 0;
        idle(20);
        chk("t6_post_rst_data", data_out, 32'h99775533);
        chk("t6_post_rst_noaud", 32'(no_audio), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
